// File: rtl/expr_sequencer_if.sv
// Token, result and ula-side signals of the RPN expression sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface expr_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_type;
  logic [WIDTH-1:0] tok_data;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             err;
  logic [DW-1:0]    depth;
  logic             ula_h;
  logic [WIDTH-1:0] ula_a;
  logic [WIDTH-1:0] ula_b;
  logic [WIDTH-1:0] ula_result;

  modport slave (
    input  tok_valid, tok_type, tok_data, res_ready, ula_result,
    output tok_ready, res_valid, res_data, err, depth, ula_h, ula_a, ula_b
  );

  modport master (
    output tok_valid, tok_type, tok_data, res_ready, ula_result,
    input  tok_ready, res_valid, res_data, err, depth, ula_h, ula_a, ula_b
  );
endinterface

// File: rtl/expr_sequencer.sv
// Postfix expression sequencer: keeps operands on a small stack and time-shares
// one external ula, one evaluation per OPER token.
module expr_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  expr_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  localparam logic [1:0] T_PUSH  = 2'b00;
  localparam logic [1:0] T_OPER  = 2'b01;
  localparam logic [1:0] T_END   = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             ula_h_q, ula_h_d;
  logic [WIDTH-1:0] ula_a_q, ula_a_d;
  logic [WIDTH-1:0] ula_b_q, ula_b_d;

  // Operand storage carries no reset; only depth_q defines which entries are live.
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  logic             tok_fire;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    left_idx;

  assign bus.tok_ready = !rst && (state_q == IDLE || state_q == ERR);
  assign tok_fire      = bus.tok_valid && bus.tok_ready;
  assign top_idx       = AW'(depth_q - DW'(1));
  assign left_idx      = AW'(depth_q - DW'(2));

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.err       = (state_q == ERR);
  assign bus.depth     = depth_q;
  assign bus.ula_h     = ula_h_q;
  assign bus.ula_a     = ula_a_q;
  assign bus.ula_b     = ula_b_q;

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    ula_h_d     = ula_h_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    we          = 1'b0;
    waddr       = depth_q[AW-1:0];
    wdata       = bus.tok_data;
    case (state_q)
      IDLE: begin
        if (tok_fire) begin
          case (bus.tok_type)
            T_PUSH: begin
              if (depth_q < DW'(DEPTH)) begin
                we      = 1'b1;
                depth_d = depth_q + DW'(1);
              end else begin
                state_d = ERR;
              end
            end
            T_OPER: begin
              if (depth_q >= DW'(2)) begin
                ula_a_d = stack_q[left_idx];
                ula_b_d = stack_q[top_idx];
                ula_h_d = bus.tok_data[0];
                state_d = EXEC;
              end else begin
                state_d = ERR;
              end
            end
            T_END: begin
              if (depth_q == DW'(1)) begin
                res_data_d  = stack_q[0];
                res_valid_d = 1'b1;
                state_d     = DONE;
              end else begin
                state_d = ERR;
              end
            end
            default: depth_d = '0;
          endcase
        end
      end
      EXEC: begin
        // Result replaces the left operand; the top entry is popped.
        we      = 1'b1;
        waddr   = left_idx;
        wdata   = bus.ula_result;
        depth_d = depth_q - DW'(1);
        state_d = IDLE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          depth_d     = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        if (tok_fire && bus.tok_type == T_CLEAR) begin
          depth_d = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ula_h_q     <= 1'b0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      ula_h_q     <= ula_h_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) stack_q[waddr] <= wdata;
  end
endmodule

// File: tb/tb_expr_sequencer.sv
// Randomized and directed bench for expr_sequencer against a queue-based RPN model.
module tb_expr_sequencer;
  localparam logic [1:0] PUSH = 2'b00, OPER = 2'b01, ENDT = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  expr_sequencer_if #(.WIDTH(16), .DEPTH(8)) bus ();

  expr_sequencer #(.WIDTH(16), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ula: any fixed combinational function works, the sequencer treats it as opaque.
  function automatic logic [15:0] ula_f(input logic h, input logic [15:0] a, input logic [15:0] b);
    return h ? (a - b) : (a + b);
  endfunction

  assign bus.ula_result = ula_f(bus.ula_h, bus.ula_a, bus.ula_b);

  logic [15:0] mstk[$];
  bit          merr;
  bit          exp_oper;
  logic [15:0] exp_a, exp_b;
  logic        exp_h;
  bit          res_pend;
  logic [15:0] exp_res;
  logic [15:0] obs_a, obs_b;
  logic        obs_h, obs_rdy;

  task automatic m_apply(input logic [1:0] t, input logic [15:0] d);
    logic [15:0] a, b;
    exp_oper = 0;
    if (t == CLR) begin
      mstk.delete();
      merr = 0;
    end else if (!merr) begin
      case (t)
        PUSH: if (mstk.size() < 8) mstk.push_back(d); else merr = 1;
        OPER: if (mstk.size() >= 2) begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          exp_a = a; exp_b = b; exp_h = d[0]; exp_oper = 1;
          mstk.push_back(ula_f(d[0], a, b));
        end else merr = 1;
        default: if (mstk.size() == 1) begin
          exp_res  = mstk[0];
          res_pend = 1;
          mstk.delete();
        end else merr = 1;
      endcase
    end
  endtask

  // Drive one token at #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [15:0] d);
    bit ok = 0;
    bus.tok_valid = 1'b1;
    bus.tok_type  = t;
    bus.tok_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (bus.tok_ready) begin
        ok = 1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.tok_valid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL tok_timeout: token type %0d never accepted (tok_ready stayed 0)", t);
    end
  endtask

  task automatic do_tok(input logic [1:0] t, input logic [15:0] d);
    send(t, d);
    m_apply(t, d);
    if (exp_oper) begin
      obs_a = bus.ula_a; obs_b = bus.ula_b; obs_h = bus.ula_h; obs_rdy = bus.tok_ready;
      @(posedge clk); #1;
    end
  endtask

  task automatic get_result(input int hold, output logic [15:0] data, output bit ok);
    ok = 0;
    data = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      data = bus.res_data;
      for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end
    res_pend = 0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (bus.tok_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b want 0", bus.tok_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_chk++; if (bus.tok_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.tok_ready); end
    n_chk++; if (bus.depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", bus.depth); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_chk++; if ({bus.ula_h, bus.ula_a, bus.ula_b} !== 33'd0) begin n_fail++; $display("FAIL reset_ula: got %h/%h/%h want 0/0/0", bus.ula_h, bus.ula_a, bus.ula_b); end
    @(posedge clk); #1;
    do_tok(PUSH, 16'h0011);
    do_tok(PUSH, 16'h0022);
    send(OPER, 16'h0001);
    rst = 1'b1;
    #1;
    n_chk++; if (bus.depth !== 4'd0) begin n_fail++; $display("FAIL exec_rst_depth: got %0d want 0", bus.depth); end
    n_chk++; if (bus.ula_a !== 16'h0) begin n_fail++; $display("FAIL exec_rst_ula_a: got %h want 0", bus.ula_a); end
    n_chk++; if (bus.tok_ready !== 1'b0) begin n_fail++; $display("FAIL exec_rst_ready: got %b want 0", bus.tok_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    mstk.delete(); merr = 0; res_pend = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL exec_rst_no_result: got %b want 0", bus.res_valid); end
    end
    n_chk++; if (bus.depth !== 4'd0 || bus.tok_ready !== 1'b1) begin n_fail++; $display("FAIL exec_rst_idle: depth %0d ready %b want 0/1", bus.depth, bus.tok_ready); end
  endtask

  task automatic test_single_op();
    logic [15:0] r; bit ok;
    do_tok(PUSH, 16'h0060);
    do_tok(PUSH, 16'h0003);
    do_tok(OPER, 16'h0001);
    n_chk++; if (obs_a !== 16'h0060 || obs_b !== 16'h0003 || obs_h !== 1'b1) begin n_fail++; $display("FAIL single_ula_in: got a=%h b=%h h=%b want 0060/0003/1", obs_a, obs_b, obs_h); end
    n_chk++; if (obs_rdy !== 1'b0) begin n_fail++; $display("FAIL single_exec_ready: got %b want 0", obs_rdy); end
    n_chk++; if (bus.depth !== 4'd1) begin n_fail++; $display("FAIL single_depth: got %0d want 1", bus.depth); end
    do_tok(ENDT, 16'h0);
    get_result(0, r, ok);
    n_chk++; if (!ok || r !== ula_f(1'b1, 16'h0060, 16'h0003)) begin n_fail++; $display("FAIL single_result: got %h (valid %b) want %h", r, ok, ula_f(1'b1, 16'h0060, 16'h0003)); end
    n_chk++; if (bus.depth !== 4'd0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: depth %0d valid %b want 0/0", bus.depth, bus.res_valid); end
  endtask

  task automatic test_chain();
    logic [15:0] r; bit ok; int extra = 0;
    do_tok(PUSH, 16'd4);
    do_tok(PUSH, 16'd5);
    do_tok(PUSH, 16'd6);
    do_tok(OPER, 16'd0);
    n_chk++; if (obs_a !== 16'd5 || obs_b !== 16'd6 || obs_h !== 1'b0) begin n_fail++; $display("FAIL chain_exec1: got a=%h b=%h h=%b want 5/6/0", obs_a, obs_b, obs_h); end
    do_tok(OPER, 16'd1);
    n_chk++; if (obs_a !== 16'd4 || obs_b !== ula_f(1'b0, 16'd5, 16'd6) || obs_h !== 1'b1) begin n_fail++; $display("FAIL chain_exec2: got a=%h b=%h h=%b want 4/%h/1", obs_a, obs_b, obs_h, ula_f(1'b0, 16'd5, 16'd6)); end
    do_tok(ENDT, 16'h0);
    get_result(1, r, ok);
    n_chk++; if (!ok || r !== exp_res) begin n_fail++; $display("FAIL chain_result: got %h (valid %b) want %h", r, ok, exp_res); end
    for (int i = 0; i < 4; i++) begin
      if (bus.res_valid) extra++;
      @(posedge clk); #1;
    end
    n_chk++; if (extra != 0) begin n_fail++; $display("FAIL chain_one_result: extra valid cycles %0d want 0", extra); end
  endtask

  task automatic test_hold();
    do_tok(PUSH, 16'hABCD);
    do_tok(PUSH, 16'h0011);
    do_tok(OPER, 16'h0000);
    do_tok(ENDT, 16'h0);
    bus.tok_valid = 1'b1; bus.tok_type = PUSH; bus.tok_data = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.tok_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: valid %b data %h ready %b want 1/%h/0", i, bus.res_valid, bus.res_data, bus.tok_ready, exp_res);
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    n_chk++; if (bus.depth !== 4'd0 || bus.tok_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: depth %0d ready %b valid %b want 0/1/0", bus.depth, bus.tok_ready, bus.res_valid);
    end
    bus.tok_valid = 1'b0;
    res_pend = 0;
  endtask

  task automatic test_errors();
    do_tok(PUSH, 16'h0007);
    do_tok(OPER, 16'h0000);
    n_chk++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %b want 1", bus.err); end
    do_tok(PUSH, 16'h0009);
    n_chk++; if (bus.depth !== 4'd1 || bus.err !== 1'b1) begin n_fail++; $display("FAIL err_discard: depth %0d err %b want 1/1", bus.depth, bus.err); end
    do_tok(CLR, 16'h0);
    n_chk++; if (bus.depth !== 4'd0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL clear: depth %0d err %b want 0/0", bus.depth, bus.err); end
    for (int i = 0; i < 8; i++) do_tok(PUSH, 16'(i * 3 + 1));
    n_chk++; if (bus.depth !== 4'd8 || bus.err !== 1'b0) begin n_fail++; $display("FAIL full_depth: depth %0d err %b want 8/0", bus.depth, bus.err); end
    do_tok(PUSH, 16'hFFFF);
    n_chk++; if (bus.err !== 1'b1 || bus.depth !== 4'd8) begin n_fail++; $display("FAIL overflow_err: err %b depth %0d want 1/8", bus.err, bus.depth); end
    do_tok(CLR, 16'h0);
    do_tok(ENDT, 16'h0);
    n_chk++; if (bus.err !== 1'b1 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL end_empty: err %b valid %b want 1/0", bus.err, bus.res_valid); end
    do_tok(CLR, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] r; bit ok;
    logic [1:0] t; int pick;
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(99);
      t = (pick < 42) ? PUSH : (pick < 75) ? OPER : (pick < 90) ? ENDT : CLR;
      do_tok(t, 16'($urandom));
      if (exp_oper) begin
        n_chk++; if (obs_a !== exp_a || obs_b !== exp_b || obs_h !== exp_h) begin
          n_fail++; $display("FAIL rnd_ula[%0d]: got %h/%h/%b want %h/%h/%b", n, obs_a, obs_b, obs_h, exp_a, exp_b, exp_h);
        end
      end
      if (res_pend) begin
        get_result($urandom_range(3), r, ok);
        n_chk++; if (!ok || r !== exp_res) begin n_fail++; $display("FAIL rnd_result[%0d]: got %h (valid %b) want %h", n, r, ok, exp_res); end
      end
      n_chk++; if (bus.depth !== 4'(mstk.size()) || bus.err !== merr) begin
        n_fail++; $display("FAIL rnd_state[%0d]: depth %0d err %b want %0d/%b", n, bus.depth, bus.err, mstk.size(), merr);
      end
    end
  endtask

  initial begin
    bus.tok_valid = 1'b0;
    bus.tok_type  = 2'b00;
    bus.tok_data  = 16'h0;
    bus.res_ready = 1'b0;
    merr = 0; res_pend = 0; exp_oper = 0;
    test_reset();
    test_single_op();
    test_chain();
    test_hold();
    test_errors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/expr_sequencer.md
# expr_sequencer

Postfix (RPN) expression sequencer that time-shares the existing 16-bit `ula` between successive operations of one expression. It accepts a token stream (push operand / operate / end / clear) over a valid-ready handshake and keeps intermediate values on an internal operand stack. For each operate token it drives one `ula` evaluation and returns the final value on a result handshake. It sits between the expression front end and a single `ula` instance, which it owns exclusively.

## Interface
- `WIDTH`, 16, operand/result width; matches `ula`.
- `DEPTH`, 8, operand stack entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tok_valid`  in  1  token present.
- `tok_ready`  out  1  sequencer accepts the token this cycle.
- `tok_type`  in  2  00 PUSH, 01 OPER, 10 END, 11 CLEAR.
- `tok_data`  in  WIDTH  PUSH: operand value; OPER: bit 0 is the `h` select; otherwise ignored.
- `res_valid`  out  1  final result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  WIDTH  final result; held stable while `res_valid`.
- `err`  out  1  sticky stack-discipline error.
- `depth`  out  clog2(DEPTH)+1  current stack occupancy.
- `ula_h`, `ula_a`, `ula_b`  out  1/WIDTH/WIDTH  registered `ula` inputs.
- `ula_result`  in  WIDTH  combinational `ula` output.

## Operation
- States: IDLE, EXEC, DONE, ERR. A token transfers when `tok_valid && tok_ready`.
- `tok_ready` = 1 in IDLE and ERR, 0 in EXEC and DONE and while `rst` is high.
- IDLE, PUSH: if depth < DEPTH, write `tok_data` to stack[depth], depth+1, stay in IDLE. If depth == DEPTH, go to ERR with stack unchanged.
- IDLE, OPER: if depth ≥ 2, load `ula_a` ← stack[depth-2] (left operand), `ula_b` ← stack[depth-1] (top), `ula_h` ← `tok_data[0]`, then go to EXEC. If depth < 2, go to ERR.
- EXEC (one cycle): write stack[depth-2] ← `ula_result`, depth−1, go to IDLE. The `ula` function is opaque to this block.
- IDLE, END: if depth == 1, `res_data` ← stack[0], `res_valid` ← 1, go to DONE. Any other depth goes to ERR.
- DONE: hold `res_valid` and `res_data` until `res_ready`. On that edge, clear `res_valid`, set depth to 0, go to IDLE.
- CLEAR (in IDLE or ERR): depth ← 0, `err` ← 0, go to IDLE.
- ERR: `err` = 1. Every token except CLEAR is accepted and discarded.
- Stack contents are not reset; only `depth` is. Entries at or above `depth` are don't-care.
- Widths: no extension or truncation; `ula_result` is stored as-is.

## Timing
- Reset values: state IDLE, `depth` 0, `res_valid` 0, `res_data` 0, `err` 0, `ula_h` 0, `ula_a` 0, `ula_b` 0.
- Asserting `rst` mid-EXEC or mid-DONE aborts the operation immediately: outputs return to reset values and no result is emitted.
- PUSH takes effect at the accepting edge; `depth` updates the same edge.
- OPER: `ula_*` are valid in the cycle after acceptance (EXEC). The stack updates at the end of EXEC. The next token can be accepted 2 cycles after the OPER transfer.
- END: `res_valid` rises the cycle after acceptance. The earliest next token is accepted the cycle after the `res_ready` edge.
- `ula_*` hold their last values outside EXEC.
- `res_ready` is ignored outside DONE.
- A `tok_valid` held high during EXEC or DONE is not consumed; the producer must hold the token stable.

## Test plan
- After reset: `tok_ready`=1, `depth`=0, `err`=0, `res_valid`=0. Asserting `rst` in EXEC returns the block to IDLE with `depth`=0 and no result.
- PUSH 0x0060, PUSH 0x0003, OPER h=1, END: in EXEC, `ula_a`=0x0060, `ula_b`=0x0003, `ula_h`=1. `res_data` equals `ula`(1, 0x0060, 0x0003), and `depth` is 1 before END.
- PUSH 4, PUSH 5, PUSH 6, OPER h=0, OPER h=1, END: first EXEC has a=5, b=6, h=0. Second EXEC has a=4, b=`ula`(0,5,6), h=1. Exactly one result is produced.
- `res_ready` held low for 5 cycles: `res_valid` and `res_data` stay stable and `tok_ready`=0. Raising `res_ready` returns the block to IDLE with `depth`=0.
- OPER with depth 1 → `err`=1. A following PUSH is accepted but `depth` is unchanged. CLEAR gives `err`=0, `depth`=0.
- 8 PUSHes leave `depth`=8; a 9th PUSH → `err`=1. END with depth 0 → `err`=1, `res_valid` stays 0.
